// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter: one requester at a time owns data_bus for a burst of
// up to MAX_BURST beats, then ownership rotates to the next pending requester.
module bus_rr_arbiter #(
    parameter int BUS_SIZE  = 16,
    parameter int WORD_SIZE = 4,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*BUS_SIZE-1:0] data_in,
    output logic [NUM_REQ-1:0]          grant,
    output logic [BUS_SIZE-1:0]         data_bus,
    output logic                        valid,
    output logic                        last,
    output logic [2:0]                  owner
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = 4;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    if ((BUS_SIZE % WORD_SIZE) != 0 || NUM_REQ < 2 || NUM_REQ > 8 ||
        MAX_BURST < 1 || MAX_BURST > 15) begin : g_param_check
        $error("bus_rr_arbiter: illegal parameter combination");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       cur;
    logic [CW-1:0]       cnt;
    logic [BUS_SIZE-1:0] lane [NUM_REQ];
    logic                pick_found;
    logic [PW-1:0]       pick_idx;
    logic [PW:0]         scan;
    logic [PW-1:0]       ptr_next;
    logic [CW-1:0]       cnt_inc;
    logic                accept;
    logic                burst_done;
    logic                release_now;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            lane[i] = data_in[i*BUS_SIZE +: BUS_SIZE];
        end
    end

    // While a burst is running ptr is always owner+1, so the scan reaches the
    // current owner last: others win first and a lone requester is regranted.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, ptr} + (PW+1)'(i);
            if (scan >= (PW+1)'(NUM_REQ)) begin
                scan = scan - (PW+1)'(NUM_REQ);
            end
            if (!pick_found && req[scan[PW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan[PW-1:0];
            end
        end
    end

    always_comb begin
        ptr_next    = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        cnt_inc     = cnt + 1'b1;
        accept      = (state == GRANT) && req[cur];
        burst_done  = accept && (cnt_inc == CW'(MAX_BURST));
        release_now = (state == GRANT) && (!req[cur] || burst_done);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            data_bus <= '0;
            valid    <= 1'b0;
            last     <= 1'b0;
            owner    <= '0;
            ptr      <= '0;
            cur      <= '0;
            cnt      <= '0;
        end else begin
            valid <= accept;
            last  <= burst_done;
            if (accept) begin
                data_bus <= lane[cur];
                owner    <= 3'(cur);
                cnt      <= cnt_inc;
            end
            // A handover in the same edge as the final beat leaves no dead cycle.
            if (state == IDLE || release_now) begin
                cnt <= '0;
                if (pick_found) begin
                    grant <= ONE << pick_idx;
                    cur   <= pick_idx;
                    ptr   <= ptr_next;
                    state <= GRANT;
                end else begin
                    grant <= '0;
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural round-robin model.
module tb_bus_rr_arbiter;

    localparam int BUS_SIZE  = 16;
    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 4;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*BUS_SIZE-1:0] data_in;
    logic [NUM_REQ-1:0]          grant;
    logic [BUS_SIZE-1:0]         data_bus;
    logic                        valid;
    logic                        last;
    logic [2:0]                  owner;

    int checks   = 0;
    int failures = 0;

    int             m_gidx;
    int             m_ptr;
    int             m_cnt;
    logic [15:0]    m_bus;
    bit             m_valid;
    bit             m_last;
    int             m_owner;

    bus_rr_arbiter #(
        .BUS_SIZE (BUS_SIZE),
        .WORD_SIZE(4),
        .NUM_REQ  (NUM_REQ),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .data_in (data_in),
        .grant   (grant),
        .data_bus(data_bus),
        .valid   (valid),
        .last    (last),
        .owner   (owner)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // First set request bit scanning upward from start, skipping exclude; -1 if none.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int start, input int exclude);
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (start + k) % NUM_REQ;
            if (r[idx] && idx != exclude) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_gidx  = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_bus   = '0;
        m_valid = 0;
        m_last  = 0;
        m_owner = 0;
    endtask

    task automatic model_step();
        int  g;
        int  p;
        bit  rel;
        if (m_gidx < 0) begin
            m_valid = 0;
            m_last  = 0;
            p = rr_pick(req, m_ptr, -1);
            if (p >= 0) begin
                m_gidx = p;
                m_ptr  = (p + 1) % NUM_REQ;
                m_cnt  = 0;
            end
        end else begin
            g   = m_gidx;
            rel = 0;
            p   = -1;
            if (req[g]) begin
                m_bus   = data_in[g*BUS_SIZE +: BUS_SIZE];
                m_valid = 1;
                m_owner = g;
                m_cnt   = m_cnt + 1;
                m_last  = (m_cnt == MAX_BURST);
                if (m_last) begin
                    rel = 1;
                    p = rr_pick(req, m_ptr, g);
                    if (p < 0) p = g;
                end
            end else begin
                m_valid = 0;
                m_last  = 0;
                rel = 1;
                p = rr_pick(req, m_ptr, -1);
            end
            if (rel) begin
                m_cnt = 0;
                if (p >= 0) begin
                    m_gidx = p;
                    m_ptr  = (p + 1) % NUM_REQ;
                end else begin
                    m_gidx = -1;
                end
            end
        end
    endtask

    task automatic checkOutput();
        logic [NUM_REQ-1:0] exp_grant;
        exp_grant = (m_gidx < 0) ? '0 : NUM_REQ'(1) << m_gidx;
        check_eq("grant", 32'(grant), 32'(exp_grant));
        check_eq("valid", 32'(valid), 32'(m_valid));
        check_eq("last", 32'(last), 32'(m_last));
        check_eq("owner", 32'(owner), 32'(m_owner));
        check_eq("data_bus", 32'(data_bus), 32'(m_bus));
        check_eq("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*BUS_SIZE-1:0] d);
        req     = r;
        data_in = d;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else       model_step();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        model_reset();
        #1;
        checkOutput();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [NUM_REQ*BUS_SIZE-1:0] pattern;
        pattern = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

        reset = 1'b1;
        applyStimulus('0, '0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_grant", 32'(grant), 32'h0);
        check_eq("reset_valid", 32'(valid), 32'h0);
        check_eq("reset_data_bus", 32'(data_bus), 32'h0);
        checkOutput();
        reset = 1'b0;

        // Rotation with all four requesting.
        applyStimulus(4'b1111, pattern);
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (c == 1) begin
                check_eq("rot_first_grant", 32'(grant), 32'h1);
                check_eq("rot_first_valid", 32'(valid), 32'h0);
            end
            if (c == 2) check_eq("rot_beat0_data", 32'(data_bus), 32'h1111);
            if (c == 5) begin
                check_eq("rot_last_beat4", 32'(last), 32'h1);
                check_eq("rot_handover", 32'(grant), 32'h2);
            end
            if (c == 6) begin
                check_eq("rot_req1_data", 32'(data_bus), 32'h2222);
                check_eq("rot_req1_valid", 32'(valid), 32'h1);
            end
            if (c == 14) check_eq("rot_req3_data", 32'(data_bus), 32'h4444);
            if (c == 18) check_eq("rot_wrap_owner", 32'(owner), 32'h0);
        end

        // Everyone drops: bus goes idle but keeps its last word.
        applyStimulus(4'b0000, pattern);
        tick();
        check_eq("idle_grant", 32'(grant), 32'h0);
        check_eq("idle_valid", 32'(valid), 32'h0);
        check_eq("idle_data_hold", 32'(data_bus), 32'h1111);
        tick();

        // Pointer wrap: after requester 3, requester 0 wins over 3.
        applyStimulus(4'b1000, pattern);
        tick();
        check_eq("wrap_grant3", 32'(grant), 32'h8);
        applyStimulus(4'b1001, pattern);
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 4) begin
                check_eq("wrap_next_grant", 32'(grant), 32'h1);
                check_eq("wrap_last", 32'(last), 32'h1);
            end
            if (c == 5) check_eq("wrap_owner0", 32'(owner), 32'h0);
        end

        // Reset in the middle of a burst.
        pulse_reset();
        applyStimulus(4'b0001, {48'h0, 16'hA5A5});
        for (int c = 1; c <= 3; c++) tick();
        check_eq("pre_reset_data", 32'(data_bus), 32'hA5A5);
        reset = 1'b1;
        model_reset();
        #1;
        check_eq("midreset_grant", 32'(grant), 32'h0);
        check_eq("midreset_valid", 32'(valid), 32'h0);
        check_eq("midreset_data_bus", 32'(data_bus), 32'h0);
        checkOutput();
        tick();
        reset = 1'b0;

        // Early drop by requester 0, then requester 1 takes a full burst.
        applyStimulus(4'b0011, {32'h0, 16'hBEEF, 16'hA5A5});
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) check_eq("restart_grant0", 32'(grant), 32'h1);
            if (c == 3) check_eq("early_last0", 32'(last), 32'h0);
        end
        applyStimulus(4'b0010, {32'h0, 16'hBEEF, 16'hA5A5});
        for (int c = 4; c <= 8; c++) begin
            tick();
            if (c == 4) begin
                check_eq("drop_grant1", 32'(grant), 32'h2);
                check_eq("drop_valid", 32'(valid), 32'h0);
            end
            if (c == 8) begin
                check_eq("req1_last", 32'(last), 32'h1);
                check_eq("req1_data", 32'(data_bus), 32'hBEEF);
            end
        end

        // Single long requester regranted with no gap.
        pulse_reset();
        applyStimulus(4'b0100, {16'h0, 16'h1234, 32'h0});
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) check_eq("single_grant", 32'(grant), 32'h4);
            if (c == 5) begin
                check_eq("single_last4", 32'(last), 32'h1);
                check_eq("single_regrant", 32'(grant), 32'h4);
            end
            if (c == 6) begin
                check_eq("single_nogap", 32'(valid), 32'h1);
                check_eq("single_last5", 32'(last), 32'h0);
            end
            if (c == 9) begin
                check_eq("single_last8", 32'(last), 32'h1);
                check_eq("single_owner", 32'(owner), 32'h2);
            end
        end

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            logic [NUM_REQ-1:0] r;
            int hold;
            r    = NUM_REQ'($urandom_range(0, 15));
            hold = $urandom_range(1, 7);
            for (int h = 0; h < hold; h++) begin
                applyStimulus(r, {$urandom, $urandom});
                if ($urandom_range(0, 99) == 0) pulse_reset();
                else tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
